spi_rx: RTL

SPI peripheral-side receiver. It is the far end of the team's write-only SPI transmitter: mode 0 (sclk idles low, data sampled on the rising edge), LSB first, one frame per cs low window. External sclk/mosi/cs pins are synchronised into the clock_in domain and sclk edges are detected there. Each frame is deserialised into a parallel word, which is presented with a one-cycle valid strobe. The block is used for board-to-board links and for loopback testing of the transmitter.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_rx_sync_bit.sv | 21 ++
 rtl/spi_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI protocol definitions for the transmitter/receiver pair.
package spi_pkg;

  typedef enum logic [1:0] {ARM, IDLE, RECEIVE, DONE} spi_rx_state_t;

  localparam int SPI_COUNT_WIDTH = 6;

  // Mode 0, LSB first: both ends of the link must agree on these.
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_rx_sync_bit.sv
// Multi-stage flop synchroniser for one asynchronous input, with selectable reset value.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock_in) begin
    if (!reset_in) chain <= {STAGES{RESET_VAL}};
    else           chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 peripheral receiver: synchronises sclk/mosi/cs and deserialises
// one LSB-first frame per cs low window into a parallel word with a valid strobe.
//
//   state   | meaning
//   ARM     | flush synchroniser, wait for cs high (drops frame in flight at reset)
//   IDLE    | wait for cs low, clear frame accumulators
//   RECEIVE | sample mosi on each sclk rise (busy)
//   DONE    | outputs updated, data_valid_out high for this cycle
module spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  cs_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [5:0]            bit_count_out,
  output logic                  data_valid_out,
  output logic                  overflow_out,
  output logic                  busy_out
);

  localparam logic [SPI_COUNT_WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [SPI_COUNT_WIDTH-1:0] DW_COUNT   = SPI_COUNT_WIDTH'(DATA_WIDTH);
  localparam logic [SPI_COUNT_WIDTH-1:0] FLUSH_LOAD = SPI_COUNT_WIDTH'(SYNC_STAGES);

  logic sclk_s, mosi_s, cs_s, sclk_prev, rise;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock_in(clock_in), .reset_in(reset_in), .d(sclk_in), .q(sclk_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock_in(clock_in), .reset_in(reset_in), .d(mosi_in), .q(mosi_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock_in(clock_in), .reset_in(reset_in), .d(cs_in), .q(cs_s));

  assign rise = sclk_s & ~sclk_prev;

  spi_rx_state_t                state;
  logic [SPI_COUNT_WIDTH-1:0]   count, count_nxt, flush_cnt;
  logic [DATA_WIDTH-1:0]        shift, shift_nxt;
  logic                         ovf, ovf_nxt;

  always_comb begin
    shift_nxt = shift;
    count_nxt = count;
    ovf_nxt   = ovf;
    if (rise) begin
      if (count < DW_COUNT) begin
        for (int i = 0; i < DATA_WIDTH; i++)
          if (count == SPI_COUNT_WIDTH'(i)) shift_nxt[i] = mosi_s;
      end else begin
        ovf_nxt = 1'b1;
      end
      if (count != COUNT_MAX) count_nxt = count + 1'b1;
    end
  end

  assign busy_out = (state == RECEIVE);

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state          <= ARM;
      flush_cnt      <= FLUSH_LOAD;
      sclk_prev      <= 1'b0;
      count          <= '0;
      shift          <= '0;
      ovf            <= 1'b0;
      data_out       <= '0;
      bit_count_out  <= '0;
      overflow_out   <= 1'b0;
      data_valid_out <= 1'b0;
    end else begin
      sclk_prev      <= sclk_s;
      data_valid_out <= 1'b0;
      case (state)
        // The cs synchroniser still holds its reset value until flushed, so
        // only a cs high seen after the flush proves the bus is really idle.
        ARM: begin
          if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
          else if (cs_s)       state     <= IDLE;
        end
        IDLE: begin
          if (!cs_s) begin
            shift <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= RECEIVE;
          end
        end
        RECEIVE: begin
          shift <= shift_nxt;
          count <= count_nxt;
          ovf   <= ovf_nxt;
          // A rise coincident with cs release still belongs to this frame.
          if (cs_s) begin
            if (count_nxt != '0) begin
              data_out       <= shift_nxt;
              bit_count_out  <= count_nxt;
              overflow_out   <= ovf_nxt;
              data_valid_out <= 1'b1;
              state          <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= ARM;
      endcase
    end
  end

endmodule
